// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts and opcode constants for the MEM pipeline stage.
// Optional feature macro used by mem_stage: MEM_UNALIGNED_CHK_EN.
package mem_stage_pkg;

    localparam int STALL_BUS      = 6;
    localparam int EX_TO_MEM_WD   = 76;
    localparam int MD_TO_MEM_WD   = 71;
    localparam int MEM_TO_WB_WD   = 70;
    localparam int HILO_TO_WB_WD  = 67;
    localparam int MEM_TO_ID_WD   = 105;

    localparam int STALL_EX_MEM   = 3;
    localparam int STALL_MEM_WB   = 4;

    localparam logic [3:0] LD_LW  = 4'b0000;
    localparam logic [3:0] LD_LB  = 4'b0001;
    localparam logic [3:0] LD_LBU = 4'b0010;
    localparam logic [3:0] LD_LH  = 4'b0011;
    localparam logic [3:0] LD_LHU = 4'b0100;
    localparam logic [3:0] ST_SB  = 4'b1100;
    localparam logic [3:0] ST_SH  = 4'b1110;
    localparam logic [3:0] ST_SW  = 4'b1101;

    localparam logic [3:0] MD_MTHI = 4'b1010;
    localparam logic [3:0] MD_MTLO = 4'b0101;

    typedef struct packed {
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

    typedef struct packed {
        logic [63:0] hilo_data;
        logic [3:0]  md_op;
        logic [1:0]  hilo_we;
        logic        hilo_en;
    } md_mem_t;

    // mthi/mtlo take their operand from the ALU path, not the mul/div unit.
    function automatic logic is_move_to_hilo(input logic [3:0] op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the byte/half/word out of a load word and sign- or zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] ld_word_i,
    input  logic [1:0]  addr_i,
    input  logic [3:0]  load_code_i,
    output logic [31:0] load_result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = ld_word_i[7:0];
        case (addr_i)
            2'b00: byte_sel = ld_word_i[7:0];
            2'b01: byte_sel = ld_word_i[15:8];
            2'b10: byte_sel = ld_word_i[23:16];
            2'b11: byte_sel = ld_word_i[31:24];
            default: byte_sel = ld_word_i[7:0];
        endcase
    end

    // Odd half addresses fall back to the low half; the fault, if enabled, is flagged upstream.
    assign half_sel = (addr_i == 2'b10) ? ld_word_i[31:16] : ld_word_i[15:0];

    always_comb begin
        load_result_o = ld_word_i;
        case (load_code_i)
            LD_LW:  load_result_o = ld_word_i;
            LD_LB:  load_result_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU: load_result_o = {24'b0, byte_sel};
            LD_LH:  load_result_o = {{16{half_sel[15]}}, half_sel};
            LD_LHU: load_result_o = {16'b0, half_sel};
            default: load_result_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: input register, stalled-load data buffer, load extraction, bus packing.
// Define MEM_UNALIGNED_CHK_EN to flag misaligned accesses and suppress their register write.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [STALL_BUS-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0]  ex_to_mem_bus,
    input  logic [MD_TO_MEM_WD-1:0]  mul_div_to_mem,
    input  logic [31:0]              data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
    output logic [HILO_TO_WB_WD-1:0] hilo_to_wb,
    output logic [MEM_TO_ID_WD-1:0]  mem_to_id_bus,
    output logic                     mem_addr_err
);

    ex_mem_t     ex_q, ex_d;
    md_mem_t     md_q, md_d;
    logic        fresh_q, fresh_d;
    logic [31:0] rdata_hold_q, rdata_hold_d;

    logic [31:0] ld_word;
    logic [31:0] load_result;
    logic [31:0] rf_wdata;
    logic        rf_we_out;
    logic        addr_err;
    logic [63:0] hilo_data_out;
    logic [1:0]  addr_lo;

    // Capture when EX/MEM runs; inject a bubble when EX/MEM stops but MEM/WB does not.
    always_comb begin
        ex_d    = ex_q;
        md_d    = md_q;
        fresh_d = 1'b0;
        if (!stall[STALL_EX_MEM]) begin
            ex_d    = ex_mem_t'(ex_to_mem_bus);
            md_d    = md_mem_t'(mul_div_to_mem);
            fresh_d = 1'b1;
        end else if (!stall[STALL_MEM_WB]) begin
            ex_d    = '0;
            md_d    = '0;
            fresh_d = 1'b1;
        end
    end

    // The SRAM word is only valid in the first MEM cycle; latch it for the rest of a stall.
    assign rdata_hold_d = fresh_q ? data_sram_rdata : rdata_hold_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_q         <= '0;
            md_q         <= '0;
            fresh_q      <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            ex_q         <= ex_d;
            md_q         <= md_d;
            fresh_q      <= fresh_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign ld_word = fresh_q ? data_sram_rdata : rdata_hold_q;
    assign addr_lo = ex_q.ex_result[1:0];

    load_align u_load_align (
        .ld_word_i     (ld_word),
        .addr_i        (addr_lo),
        .load_code_i   (ex_q.ram_wen),
        .load_result_o (load_result)
    );

    assign rf_wdata = ex_q.sel_rf_res ? load_result : ex_q.ex_result;

`ifdef MEM_UNALIGNED_CHK_EN
    always_comb begin
        addr_err = 1'b0;
        if (ex_q.ram_en) begin
            if (((ex_q.ram_wen == LD_LW) || (ex_q.ram_wen == ST_SW)) && (addr_lo != 2'b00))
                addr_err = 1'b1;
            if (((ex_q.ram_wen == LD_LH) || (ex_q.ram_wen == LD_LHU) || (ex_q.ram_wen == ST_SH))
                && addr_lo[0])
                addr_err = 1'b1;
        end
    end
    assign rf_we_out = ex_q.rf_we & ~addr_err;
`else
    assign addr_err  = 1'b0;
    assign rf_we_out = ex_q.rf_we;
`endif

    assign mem_addr_err  = addr_err;
    assign hilo_data_out = is_move_to_hilo(md_q.md_op) ? {ex_q.ex_result, ex_q.ex_result}
                                                       : md_q.hilo_data;

    assign mem_to_wb_bus = {ex_q.pc, rf_we_out, ex_q.rf_waddr, rf_wdata};
    assign hilo_to_wb    = {md_q.hilo_en, md_q.hilo_we, hilo_data_out};
    assign mem_to_id_bus = {md_q.hilo_en, hilo_data_out, md_q.hilo_we,
                            rf_we_out, ex_q.rf_waddr, rf_wdata};

    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5], stall[2:0]};

endmodule
